// File: rtl/piezo_pkg.sv
// Shared types, 50 MHz default timing constants and a counter-width helper
// for the piezo timebase.
package piezo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BEEP,
    GAP
  } cad_state_t;

  localparam int PIEZO_PERIOD_CYC = 100_000_000;
  localparam int PIEZO_WINDOW_CYC = 12_500_000;
  localparam int PIEZO_LO_HALF    = 25_000;
  localparam int PIEZO_HI_HALF    = 12_500;
  localparam int PIEZO_CHIRP_CYC  = 6_250_000;

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tone_div.sv
// Square-wave divider: toggles every HALF enabled clocks, and clears output
// and counter whenever disabled so each enable starts in phase.
module tone_div
  import piezo_pkg::*;
#(
  parameter int HALF = PIEZO_LO_HALF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tone
);

  localparam int CW = cnt_w(HALF);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (cnt == CW'(HALF - 1)) begin
      cnt  <= '0;
      tone <= ~tone;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/piezo_timer.sv
// Piezo timebase: beep-window cadence FSM plus low (steering) and high
// (warning) tone dividers. Define PIEZO_HI_CHIRP_EN to chop the high tone.
module piezo_timer
  import piezo_pkg::*;
#(
  parameter int PERIOD_CYC = PIEZO_PERIOD_CYC,
  parameter int WINDOW_CYC = PIEZO_WINDOW_CYC,
  parameter int LO_HALF    = PIEZO_LO_HALF,
  parameter int HI_HALF    = PIEZO_HI_HALF,
  parameter int CHIRP_CYC  = PIEZO_CHIRP_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_steer,
  input  logic batt_low,
  input  logic ovr_spd,
  output logic timer_2sec,
  output logic timer2_ensteer,
  output logic timer3_battspd
);

  localparam int PW = cnt_w(PERIOD_CYC);

  if (WINDOW_CYC >= PERIOD_CYC || WINDOW_CYC < 1) begin : g_bad_window
    $error("piezo_timer: WINDOW_CYC must be in 1..PERIOD_CYC-1");
  end
  if (CHIRP_CYC < 1) begin : g_bad_chirp
    $error("piezo_timer: CHIRP_CYC must be at least 1");
  end

  cad_state_t    state;
  logic [PW-1:0] pcnt;
  logic          warn;
  logic          lo_en;
  logic          hi_en;

  assign warn = batt_low | ovr_spd;

  // timer_2sec is loaded with the same decision as the next state, so it
  // always equals (state == BEEP) without a combinational output path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pcnt       <= '0;
      timer_2sec <= 1'b0;
    end else if (!en_steer) begin
      state      <= IDLE;
      pcnt       <= '0;
      timer_2sec <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state      <= BEEP;
          pcnt       <= '0;
          timer_2sec <= 1'b1;
        end
        BEEP: begin
          pcnt <= pcnt + PW'(1);
          if (pcnt == PW'(WINDOW_CYC - 1)) begin
            state      <= GAP;
            timer_2sec <= 1'b0;
          end else begin
            timer_2sec <= 1'b1;
          end
        end
        GAP: begin
          if (pcnt == PW'(PERIOD_CYC - 1)) begin
            state      <= BEEP;
            pcnt       <= '0;
            timer_2sec <= 1'b1;
          end else begin
            pcnt       <= pcnt + PW'(1);
            timer_2sec <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          pcnt       <= '0;
          timer_2sec <= 1'b0;
        end
      endcase
    end
  end

  // Gating with en_steer kills the low tone on the same edge that ends the
  // window when steering drops mid-window.
  assign lo_en = (state == BEEP) && en_steer;

`ifdef PIEZO_HI_CHIRP_EN
  localparam int CCW = cnt_w(2 * CHIRP_CYC);

  logic [CCW-1:0] ccnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccnt <= '0;
    end else if (!warn) begin
      ccnt <= '0;
    end else if (ccnt == CCW'(2 * CHIRP_CYC - 1)) begin
      ccnt <= '0;
    end else begin
      ccnt <= ccnt + CCW'(1);
    end
  end

  // First CHIRP_CYC counts of each chirp period are the audible slice.
  assign hi_en = warn && (ccnt < CCW'(CHIRP_CYC));
`else
  assign hi_en = warn;
`endif

  tone_div #(
    .HALF(LO_HALF)
  ) u_lo_div (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (lo_en),
    .tone (timer2_ensteer)
  );

  tone_div #(
    .HALF(HI_HALF)
  ) u_hi_div (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (hi_en),
    .tone (timer3_battspd)
  );

endmodule

// File: tb/tb_piezo_timer.sv
// Directed bench for piezo_timer with small timing parameters; expected
// waveforms come from closed-form window/tone phase formulas.
module tb_piezo_timer;

  localparam int PER = 40;
  localparam int WIN = 10;
  localparam int LO  = 3;
  localparam int HI  = 2;
  localparam int CH  = 6;

  logic clk;
  logic rst_n;
  logic en_steer;
  logic batt_low;
  logic ovr_spd;
  logic timer_2sec;
  logic timer2_ensteer;
  logic timer3_battspd;

  int checks;
  int failures;

  piezo_timer #(
    .PERIOD_CYC(PER),
    .WINDOW_CYC(WIN),
    .LO_HALF   (LO),
    .HI_HALF   (HI),
    .CHIRP_CYC (CH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en_steer      (en_steer),
    .batt_low      (batt_low),
    .ovr_spd       (ovr_spd),
    .timer_2sec    (timer_2sec),
    .timer2_ensteer(timer2_ensteer),
    .timer3_battspd(timer3_battspd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle, so outputs reflect that edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // p = edges since the edge that first sampled en_steer high (p=0 there).
  function automatic logic exp_win(input int p);
    return ((p % PER) < WIN);
  endfunction

  function automatic logic exp_lo(input int p);
    int q;
    q = p % PER;
    if (q < WIN) return logic'((q / LO) % 2);
    if (q == WIN) return logic'(((WIN - 1) / LO) % 2);
    return 1'b0;
  endfunction

  // u = 1 on the first edge that samples a warning high.
  function automatic logic exp_hi(input int u);
`ifdef PIEZO_HI_CHIRP_EN
    int q;
    q = (u - 1) % (2 * CH);
    if (q >= CH) return 1'b0;
    return logic'(((q + 1) / HI) % 2);
`else
    return logic'((u / HI) % 2);
`endif
  endfunction

  task automatic run_mix(input string name, input int n, input int base,
                         input bit cad, input bit hi);
    for (int i = 0; i < n; i++) begin
      step();
      check($sformatf("%s t2s@%0d", name, base + i), timer_2sec,
            cad ? exp_win(base + i) : 1'b0);
      check($sformatf("%s lo@%0d", name, base + i), timer2_ensteer,
            cad ? exp_lo(base + i) : 1'b0);
      check($sformatf("%s hi@%0d", name, i + 1), timer3_battspd,
            hi ? exp_hi(i + 1) : 1'b0);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, " t2s"}, timer_2sec, 1'b0);
    check({name, " lo"}, timer2_ensteer, 1'b0);
    check({name, " hi"}, timer3_battspd, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    en_steer = 1'b1;
    batt_low = 1'b1;
    ovr_spd  = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_hold");

    en_steer = 1'b0;
    batt_low = 1'b0;
    ovr_spd  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_all_zero("post_reset_idle");

    // Cadence: 100 cycles of steering enable, then on into the next window.
    en_steer = 1'b1;
    run_mix("cadence", 100, 0, 1'b1, 1'b0);
    run_mix("cadence", 26, 100, 1'b1, 1'b0);

    // Five cycles into the window (p=5): drop en_steer.
    check("pre_drop lo", timer2_ensteer, 1'b1);
    en_steer = 1'b0;
    step();
    check("drop t2s", timer_2sec, 1'b0);
    check("drop lo", timer2_ensteer, 1'b0);
    step();
    check_all_zero("drop_hold");

    // Re-raise: a fresh full window starts at p=0.
    en_steer = 1'b1;
    run_mix("reraise", 45, 0, 1'b1, 1'b0);
    en_steer = 1'b0;
    step();
    step();
    check_all_zero("cad_off");

    // Over-speed pulse.
    ovr_spd = 1'b1;
    run_mix("ovr_spd", 20, 0, 1'b0, 1'b1);
    ovr_spd = 1'b0;
    step();
    check("ovr_spd off hi", timer3_battspd, 1'b0);
    step();

    // Battery-low pulse, ending while the tone is high.
    batt_low = 1'b1;
    run_mix("batt_low", 18, 0, 1'b0, 1'b1);
    check("batt_low pre_off hi", timer3_battspd, exp_hi(18));
    batt_low = 1'b0;
    step();
    check("batt_low off hi", timer3_battspd, 1'b0);
    step();

    // Overlap: both tones from the same starting edge.
    en_steer = 1'b1;
    batt_low = 1'b1;
    run_mix("overlap", 46, 0, 1'b1, 1'b1);

    // Asynchronous reset mid-cycle inside a window with both tones active.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_mix("restart", 12, 0, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
